alu_sweep_driver: RTL and testbench

Self-test sequencer for the 4-bit ALU tile, on the far side of its 8-bit operand/opcode port. On `start` it drives every `{opcode, B, A}` vector of the enabled opcodes into the ALU, samples the ALU status byte after a fixed settle time, and folds the samples into a 16-bit MISR signature with zero- and carry-flag counts. It sits between the ALU's dedicated input/output pins and the test-control logic, which compares the final signature and counts against golden values.

---
 rtl/alu_pkg.sv | 73 +++++++
 rtl/alu_sweep_misr.sv | 27 ++
 rtl/alu_sweep_driver.sv | 149 ++++++++++++++
 tb/tb_alu_sweep_driver.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU tile self-test: opcode encoding,
// operand/status byte layouts, sweep FSM states and the MISR helpers.
package alu_pkg;

    // ALU opcode encoding as seen on alu_in[7:5].
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    // Signature register constants (CRC-16/CCITT polynomial, all-ones seed).
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Byte driven into the ALU: [7:5]=opcode, [4]=B, [3:0]=A.
    typedef struct packed {
        logic [2:0] op;
        logic       b;
        logic [3:0] a;
    } alu_in_t;

    // Status byte returned by the ALU: [7:6] reserved (must read 0),
    // [5]=zero, [4]=carry, [3:0]=result.
    typedef struct packed {
        logic [1:0] rsvd;
        logic       zero;
        logic       carry;
        logic [3:0] result;
    } alu_out_t;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } sweep_state_e;

    // Result of searching the opcode mask for the next enabled opcode.
    typedef struct packed {
        logic       valid;
        logic [2:0] op;
    } op_sel_t;

    // Lowest enabled opcode that is >= 'from'. 'from' is 4 bits wide so a
    // search starting past the last opcode (8) simply finds nothing.
    function automatic op_sel_t find_op(input logic [7:0] mask, input logic [3:0] from);
        op_sel_t sel;
        sel.valid = 1'b0;
        sel.op    = 3'd0;
        // Walk downwards so the lowest qualifying opcode is the last one kept.
        for (int i = int'(OP_SHR); i >= 0; i--) begin
            if (i >= int'(from) && mask[i]) begin
                sel.valid = 1'b1;
                sel.op    = i[2:0];
            end
        end
        return sel;
    endfunction

    // One MISR step: shift left, fold in the status byte, apply the
    // polynomial when the bit shifted out was set.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [7:0] data);
        return {sig[14:0], 1'b0} ^ {8'h00, data} ^ (sig[15] ? MISR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/alu_sweep_misr.sv
// 16-bit multiple-input signature register that compresses the ALU status
// bytes of a sweep. Reloads the seed on load_seed, advances on shift_en.
module alu_sweep_misr
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_seed,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [15:0] signature
);

    // Signature register: seed on reset or sweep start, fold one sample per shift.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block evaluation order.
        if (rst) begin
            signature <= MISR_SEED;
        end else if (load_seed) begin
            signature <= MISR_SEED;
        end else if (shift_en) begin
            signature <= misr_step(signature, data);
        end
    end

endmodule

// File: rtl/alu_sweep_driver.sv
// Self-test sequencer for the 4-bit ALU tile. On start it walks every
// {opcode, B, A} vector of the enabled opcodes in ascending order, holds
// each for SETTLE cycles, samples the status byte and accumulates a MISR
// signature plus vector, zero-flag and carry-flag counts.
module alu_sweep_driver
    import alu_pkg::*;
#(
    parameter logic [7:0] OP_MASK = 8'hFF,
    parameter int         SETTLE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  alu_in,
    input  logic [7:0]  alu_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [8:0]  vec_count,
    output logic [8:0]  zero_count,
    output logic [8:0]  carry_count,
    output logic        error
);

    // Settle counter reload: DRIVE lasts SETTLE cycles, counting down to 0.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    sweep_state_e state;
    alu_in_t      index;
    logic [3:0]   settle_cnt;

    alu_out_t     sample;
    op_sel_t      first_op;
    op_sel_t      next_op;
    alu_in_t      next_index;
    logic         at_op_end;
    logic         more_vecs;
    logic         accept;
    logic         shift_en;

    // index is cleared whenever the sweep is not running, so it doubles as
    // the registered alu_in value (0 in IDLE and FINISH).
    assign alu_in = index;
    assign sample = alu_out;

    // First enabled opcode depends only on the mask and folds to a constant.
    assign first_op = find_op(OP_MASK, 4'd0);

    // Next-vector selection: step within an opcode, or jump from x1F straight
    // to x00 of the next enabled opcode so masked opcodes cost no cycles.
    always_comb begin
        // NOTE: every signal written here gets a value on every path before
        // any conditional override, otherwise a latch would be inferred.
        at_op_end  = ({index.b, index.a} == 5'h1F);
        next_op    = find_op(OP_MASK, {1'b0, index.op} + 4'd1);
        next_index = alu_in_t'(index + 8'd1);
        if (at_op_end) begin
            next_index = '{op: next_op.op, b: 1'b0, a: 4'h0};
        end
        more_vecs  = !at_op_end || next_op.valid;
    end

    // start is level-sampled and only honoured in IDLE; the MISR reseeds on
    // the accepting edge and advances on the edge that ends each SAMPLE.
    assign accept   = (state == ST_IDLE) && start;
    assign shift_en = (state == ST_SAMPLE);

    alu_sweep_misr u_misr (
        .clk       (clk),
        .rst       (rst),
        .load_seed (accept),
        .shift_en  (shift_en),
        .data      (sample),
        .signature (signature)
    );

    // Sweep FSM with registered outputs, vector index and result counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            index       <= '0;
            settle_cnt  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            vec_count   <= '0;
            zero_count  <= '0;
            carry_count <= '0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec_count   <= '0;
                        zero_count  <= '0;
                        carry_count <= '0;
                        error       <= 1'b0;
                        if (first_op.valid) begin
                            state      <= ST_DRIVE;
                            index      <= '{op: first_op.op, b: 1'b0, a: 4'h0};
                            settle_cnt <= SETTLE_LAST;
                            busy       <= 1'b1;
                        end else begin
                            // Nothing to sweep: report completion immediately.
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_DRIVE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    // At most 256 samples per sweep, so 9-bit counts never wrap.
                    vec_count   <= vec_count + 9'd1;
                    zero_count  <= zero_count + 9'(sample.zero);
                    carry_count <= carry_count + 9'(sample.carry);
                    error       <= error | (|sample.rsvd);
                    if (more_vecs) begin
                        state      <= ST_DRIVE;
                        index      <= next_index;
                        settle_cnt <= SETTLE_LAST;
                    end else begin
                        state <= ST_FINISH;
                        index <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                ST_FINISH: begin
                    // start is ignored here; a held start is seen next in IDLE.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench for alu_sweep_driver. Five instances cover different
// opcode masks and settle times; a behavioural ALU answers each one, and a
// reference walk of the same ALU produces the expected signatures and counts.
module tb_alu_sweep_driver;

    localparam int         N_DUT = 5;
    localparam logic [7:0] MASKS   [N_DUT] = '{8'h01, 8'h04, 8'h00, 8'hFF, 8'h22};
    localparam int         SETTLES [N_DUT] = '{1, 1, 1, 1, 3};

    logic        clk = 1'b0;
    logic        rst;
    logic        inject = 1'b0;
    logic        start       [N_DUT];
    logic [7:0]  alu_in      [N_DUT];
    logic [7:0]  alu_out     [N_DUT];
    logic        busy        [N_DUT];
    logic        done        [N_DUT];
    logic [15:0] signature   [N_DUT];
    logic [8:0]  vec_count   [N_DUT];
    logic [8:0]  zero_count  [N_DUT];
    logic [8:0]  carry_count [N_DUT];
    logic        error       [N_DUT];

    int n_vec  = 0;
    int n_miss = 0;
    int done_seen [N_DUT] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        alu_sweep_driver #(
            .OP_MASK (MASKS[g]),
            .SETTLE  (SETTLES[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .alu_in      (alu_in[g]),
            .alu_out     (alu_out[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .signature   (signature[g]),
            .vec_count   (vec_count[g]),
            .zero_count  (zero_count[g]),
            .carry_count (carry_count[g]),
            .error       (error[g])
        );
    end

    // Behavioural 4-bit ALU: returns {2'b00, zero, carry, result}.
    function automatic logic [7:0] alu_model(input logic [7:0] v);
        logic [3:0] a;
        logic       b;
        logic [4:0] w;
        a = v[3:0];
        b = v[4];
        w = 5'd0;
        case (v[7:5])
            3'd0:    w = {1'b0, a} + {4'd0, b};
            3'd1:    w = {1'b0, a} - {4'd0, b};
            3'd2:    w = {1'b0, a & {3'd0, b}};
            3'd3:    w = {1'b0, a | {3'd0, b}};
            3'd4:    w = {1'b0, a ^ {3'd0, b}};
            3'd5:    w = {1'b0, ~a};
            3'd6:    w = b ? {a, 1'b0} : {1'b0, a};
            default: w = b ? {a[0], 1'b0, a[3:1]} : {1'b0, a};
        endcase
        return {2'b00, (w[3:0] == 4'd0), w[4], w[3:0]};
    endfunction

    // ALU tiles; instance 3 can be made to flag a reserved bit on vector 8'h05.
    always_comb begin
        for (int k = 0; k < N_DUT; k++) begin
            alu_out[k] = alu_model(alu_in[k]);
        end
        if (inject && alu_in[3] == 8'h05) begin
            alu_out[3][7] = 1'b1;
        end
    end

    // Count done pulses per instance, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < N_DUT; k++) begin
            if (done[k]) done_seen[k] = done_seen[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference sweep over the behavioural ALU, in ascending vector order.
    task automatic model_sweep(input logic [7:0] mask, input logic fault,
                               output logic [15:0] sig, output int vecs,
                               output int zeros, output int carries, output logic err);
        logic [7:0] o;
        logic       fb;
        sig = 16'hFFFF;
        vecs = 0; zeros = 0; carries = 0; err = 1'b0;
        for (int v = 0; v < 256; v++) begin
            if (mask[v / 32]) begin
                o = alu_model(8'(v));
                if (fault && v == 5) o[7] = 1'b1;
                fb  = sig[15];
                sig = {sig[14:0], 1'b0} ^ {8'h00, o};
                if (fb) sig = sig ^ 16'h1021;
                vecs++;
                zeros   += int'(o[5]);
                carries += int'(o[4]);
                err = err | o[7] | o[6];
            end
        end
    endtask

    // Pulse start for one cycle, then count cycles from acceptance to done.
    // Optionally pokes start again at cycle poke_at and records alu_in at probe_at.
    task automatic run_sweep(input int k, input int budget, input int poke_at, input int probe_at,
                             output int cycles, output logic [7:0] first_vec,
                             output logic first_busy, output logic [7:0] probed);
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k]   = 1'b0;
        first_vec  = alu_in[k];
        first_busy = busy[k];
        probed     = 8'h00;
        cycles     = 0;
        while (!done[k] && cycles < budget) begin
            if (cycles == probe_at) probed = alu_in[k];
            start[k] = (cycles == poke_at);
            @(posedge clk);
            #1;
            cycles++;
        end
        start[k] = 1'b0;
        check($sformatf("done_reached_%0d", k), 32'(done[k]), 32'd1);
        check($sformatf("done_busy_low_%0d", k), 32'(busy[k]), 32'd0);
        @(posedge clk);
        #1;
        check($sformatf("done_one_cycle_%0d", k), 32'(done[k]), 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [7:0]  fv;
        logic        fb;
        logic [7:0]  pr;
        logic [15:0] m_sig;
        logic [15:0] clean_sig;
        int          m_vec, m_zero, m_carry;
        logic        m_err;
        int          base;

        for (int k = 0; k < N_DUT; k++) start[k] = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state.
        check("rst_busy",      32'(busy[3]),      32'd0);
        check("rst_done",      32'(done[3]),      32'd0);
        check("rst_alu_in",    32'(alu_in[3]),    32'h00);
        check("rst_signature", 32'(signature[3]), 32'hFFFF);
        check("rst_vec_count", 32'(vec_count[3]), 32'd0);
        check("rst_error",     32'(error[3]),     32'd0);
        rst = 1'b0;

        // ADD only, SETTLE=1: 32 vectors x 2 cycles.
        model_sweep(8'h01, 1'b0, m_sig, m_vec, m_zero, m_carry, m_err);
        run_sweep(0, 2000, -1, -1, cyc, fv, fb, pr);
        check("add_latency",     32'(cyc),            32'd64);
        check("add_first_busy",  32'(fb),             32'd1);
        check("add_vec_count",   32'(vec_count[0]),   32'd32);
        check("add_zero_count",  32'(zero_count[0]),  32'd2);
        check("add_carry_count", 32'(carry_count[0]), 32'd1);
        check("add_error",       32'(error[0]),       32'd0);
        check("add_signature",   32'(signature[0]),   32'(m_sig));

        // AND only.
        model_sweep(8'h04, 1'b0, m_sig, m_vec, m_zero, m_carry, m_err);
        run_sweep(1, 2000, -1, -1, cyc, fv, fb, pr);
        check("and_first_vec",   32'(fv),             32'h40);
        check("and_vec_count",   32'(vec_count[1]),   32'd32);
        check("and_zero_count",  32'(zero_count[1]),  32'd24);
        check("and_carry_count", 32'(carry_count[1]), 32'd0);
        check("and_signature",   32'(signature[1]),   32'(m_sig));

        // Empty mask: done right after acceptance, seed signature, no counts.
        run_sweep(2, 20, -1, -1, cyc, fv, fb, pr);
        check("none_latency",     32'(cyc),            32'd0);
        check("none_busy",        32'(fb),             32'd0);
        check("none_signature",   32'(signature[2]),   32'hFFFF);
        check("none_vec_count",   32'(vec_count[2]),   32'd0);
        check("none_zero_count",  32'(zero_count[2]),  32'd0);
        check("none_carry_count", 32'(carry_count[2]), 32'd0);

        // start held across FINISH->IDLE re-arms on the first IDLE cycle.
        @(negedge clk);
        start[2] = 1'b1;
        @(posedge clk); #1;
        check("held_done_a", 32'(done[2]), 32'd1);
        @(posedge clk); #1;
        check("held_done_b", 32'(done[2]), 32'd0);
        @(posedge clk); #1;
        check("held_done_c", 32'(done[2]), 32'd1);
        start[2] = 1'b0;
        @(posedge clk); #1;
        check("held_done_d", 32'(done[2]), 32'd0);

        // Full mask, clean ALU.
        model_sweep(8'hFF, 1'b0, m_sig, m_vec, m_zero, m_carry, m_err);
        clean_sig = m_sig;
        run_sweep(3, 2000, -1, -1, cyc, fv, fb, pr);
        check("full_latency",     32'(cyc),            32'd512);
        check("full_vec_count",   32'(vec_count[3]),   32'd256);
        check("full_zero_count",  32'(zero_count[3]),  32'(m_zero));
        check("full_carry_count", 32'(carry_count[3]), 32'(m_carry));
        check("full_error",       32'(error[3]),       32'd0);
        check("full_signature",   32'(signature[3]),   32'(clean_sig));

        // Full mask with a reserved status bit on vector 8'h05.
        inject = 1'b1;
        model_sweep(8'hFF, 1'b1, m_sig, m_vec, m_zero, m_carry, m_err);
        run_sweep(3, 2000, -1, -1, cyc, fv, fb, pr);
        inject = 1'b0;
        check("fault_error",         32'(error[3]),                  32'd1);
        check("fault_vec_count",     32'(vec_count[3]),              32'd256);
        check("fault_sig_differs",   32'(signature[3] != clean_sig), 32'd1);
        check("fault_signature",     32'(signature[3]),              32'(m_sig));

        // Opcodes 1 and 5 with SETTLE=3; a start pulse mid-sweep is ignored.
        model_sweep(8'h22, 1'b0, m_sig, m_vec, m_zero, m_carry, m_err);
        base = done_seen[4];
        run_sweep(4, 2000, 50, 128, cyc, fv, fb, pr);
        repeat (5) @(posedge clk);
        #1;
        check("s3_first_vec",    32'(fv),                     32'h20);
        check("s3_first_busy",   32'(fb),                     32'd1);
        check("s3_skip_to_op5",  32'(pr),                     32'hA0);
        check("s3_latency",      32'(cyc),                    32'd256);
        check("s3_vec_count",    32'(vec_count[4]),           32'd64);
        check("s3_signature",    32'(signature[4]),           32'(m_sig));
        check("s3_single_done",  32'(done_seen[4] - base),    32'd1);
        check("s3_idle_after",   32'(busy[4]),                32'd0);

        // Reset in the middle of a full sweep, then a clean rerun.
        @(negedge clk);
        start[3] = 1'b1;
        @(posedge clk); #1;
        start[3] = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        base = done_seen[3];
        rst = 1'b1;
        #1;
        check("midrst_busy",        32'(busy[3]),        32'd0);
        check("midrst_done",        32'(done[3]),        32'd0);
        check("midrst_alu_in",      32'(alu_in[3]),      32'h00);
        check("midrst_signature",   32'(signature[3]),   32'hFFFF);
        check("midrst_vec_count",   32'(vec_count[3]),   32'd0);
        check("midrst_zero_count",  32'(zero_count[3]),  32'd0);
        check("midrst_carry_count", 32'(carry_count[3]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_seen[3] - base), 32'd0);
        check("midrst_idle",    32'(busy[3]),             32'd0);
        run_sweep(3, 2000, -1, -1, cyc, fv, fb, pr);
        check("rerun_latency",   32'(cyc),            32'd512);
        check("rerun_vec_count", 32'(vec_count[3]),   32'd256);
        check("rerun_signature", 32'(signature[3]),   32'(clean_sig));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
